// File: rtl/prng_word_reader.sv
`default_nettype none
// ==== prng_word_reader : buffers one 128-bit PCG sample, serves it as WORD_W words ====
// ==== over valid/ready, and halts with a sticky flag on a stuck generator.  rev 1.0 ====
module prng_word_reader #(
  parameter int WORD_W      = 32,
  parameter int WARMUP      = 2,
  parameter int STUCK_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      rand_in,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       word_count,
  output logic              stuck_err
);

  localparam int NW  = 128 / WORD_W;
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int SCW = $clog2(STUCK_LIMIT);

  localparam logic [1:0] S_WARM  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WCW-1:0]   r_warm_cnt;
  logic [127:0]     r_hold;
  logic [127:0]     r_prev;
  logic [SCW-1:0]   r_same_cnt;
  logic [IW-1:0]    r_idx;
  logic [31:0]      r_word_count;
  logic             w_same;
  logic             w_stuck;
  logic             w_hs;
  logic             w_last_word;
  logic             w_warm_done;
  logic [WORD_W-1:0] w_words [NW];

  assign w_same      = (rand_in == r_prev);
  assign w_stuck     = (r_state == S_SERVE) && w_same && (r_same_cnt == SCW'(STUCK_LIMIT - 2));
  assign w_hs        = rd_valid && rd_ready;
  assign w_last_word = (r_idx == IW'(NW - 1));
  assign w_warm_done = (r_warm_cnt == WCW'(WARMUP - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WARM;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WARM:  if (w_warm_done) w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_SERVE;
      S_SERVE: if (w_stuck) w_next_state = S_ERR;
      default: w_next_state = S_ERR;
    endcase
  end

  // Valid and error flags follow the state directly, so an async reset clears them at once.
  always_comb begin
    rd_valid  = 1'b0;
    stuck_err = 1'b0;
    case (r_state)
      S_SERVE: rd_valid  = 1'b1;
      S_ERR:   stuck_err = 1'b1;
      default: begin
        rd_valid  = 1'b0;
        stuck_err = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm_cnt   <= '0;
      r_hold       <= '0;
      r_prev       <= '0;
      r_same_cnt   <= '0;
      r_idx        <= '0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        S_WARM: r_warm_cnt <= r_warm_cnt + WCW'(1);
        S_LOAD: begin
          r_hold     <= rand_in;
          r_prev     <= rand_in;
          r_same_cnt <= '0;
          r_idx      <= '0;
        end
        S_SERVE: begin
          r_same_cnt <= w_same ? (r_same_cnt + SCW'(1)) : '0;
          r_prev     <= rand_in;
          if (w_hs) begin
            r_word_count <= r_word_count + 32'd1;
            // Refill on the edge that consumes the last word so streaming has no bubble.
            if (w_last_word) begin
              r_idx  <= '0;
              r_hold <= rand_in;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_words
    assign w_words[g] = r_hold[g*WORD_W +: WORD_W];
  end

  assign rd_data    = w_words[r_idx];
  assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_prng_word_reader.sv
`default_nettype none
// ==== tb_prng_word_reader : directed table, corner sequences and a random run ====
// ==== checked against a queue-based model of the word stream.            rev 1.0 ====
module tb_prng_word_reader;

  localparam int WORD_W      = 32;
  localparam int NW          = 4;
  localparam int WARMUP      = 2;
  localparam int STUCK_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [127:0]      rand_in = '0;
  logic              rd_ready = 1'b0;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic [31:0]       word_count;
  logic              stuck_err;

  int n_checks = 0;
  int n_errors = 0;

  prng_word_reader #(
    .WORD_W(WORD_W), .WARMUP(WARMUP), .STUCK_LIMIT(STUCK_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .word_count(word_count),
    .stuck_err(stuck_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Model: a queue of words still to be served from the current sample.
  int                m_edges;
  logic              m_valid;
  logic              m_err;
  logic [31:0]       m_count;
  logic [127:0]      m_prev;
  int                m_run;
  logic [WORD_W-1:0] m_q[$];

  typedef struct {
    logic        rdy;
    int          seed;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [31:0] exp_count;
  } vec_t;
  vec_t tbl[22];

  function automatic logic [127:0] R(input int e);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'(e*16 + j);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_valid = 1'b0; m_err = 1'b0; m_count = '0;
    m_prev = '0; m_run = 0; m_q.delete();
  endtask

  task automatic load_words(input logic [127:0] rin);
    m_q.delete();
    for (int j = 0; j < NW; j++) m_q.push_back(rin[j*WORD_W +: WORD_W]);
  endtask

  task automatic model_edge(input logic rdy, input logic [127:0] rin);
    if (m_err) return;
    if (!m_valid) begin
      m_edges++;
      if (m_edges == WARMUP + 1) begin
        load_words(rin);
        m_prev = rin; m_run = 1; m_valid = 1'b1;
      end
    end else begin
      if (rdy) begin
        m_count = m_count + 32'd1;
        void'(m_q.pop_front());
        if (m_q.size() == 0) load_words(rin);
      end
      m_run  = (rin == m_prev) ? m_run + 1 : 1;
      m_prev = rin;
      if (m_run >= STUCK_LIMIT) begin
        m_err = 1'b1; m_valid = 1'b0;
      end
    end
  endtask

  task automatic cycle_raw(input logic rdy, input logic [127:0] rin);
    rd_ready = rdy;
    rand_in  = rin;
    @(posedge clk);
    model_edge(rdy, rin);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 128'(rd_valid), 128'(m_valid));
    chk({tag, "_err"}, 128'(stuck_err), 128'(m_err));
    chk({tag, "_count"}, 128'(word_count), 128'(m_count));
    if (!m_err) chk({tag, "_data"}, 128'(rd_data), m_valid ? 128'(m_q[0]) : 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [127:0] last;
    logic [127:0] rin;

    tbl[0]  = '{1'b1,  1, 1'b0, 32'h000,  0};
    tbl[1]  = '{1'b1,  2, 1'b0, 32'h000,  0};
    tbl[2]  = '{1'b1,  3, 1'b1, 32'h030,  0};
    tbl[3]  = '{1'b1,  4, 1'b1, 32'h031,  1};
    tbl[4]  = '{1'b1,  5, 1'b1, 32'h032,  2};
    tbl[5]  = '{1'b1,  6, 1'b1, 32'h033,  3};
    tbl[6]  = '{1'b1,  7, 1'b1, 32'h070,  4};
    tbl[7]  = '{1'b1,  8, 1'b1, 32'h071,  5};
    tbl[8]  = '{1'b1,  9, 1'b1, 32'h072,  6};
    tbl[9]  = '{1'b1, 10, 1'b1, 32'h073,  7};
    tbl[10] = '{1'b1, 11, 1'b1, 32'h0B0,  8};
    tbl[11] = '{1'b1, 12, 1'b1, 32'h0B1,  9};
    tbl[12] = '{1'b1, 13, 1'b1, 32'h0B2, 10};
    tbl[13] = '{1'b1, 14, 1'b1, 32'h0B3, 11};
    tbl[14] = '{1'b1, 15, 1'b1, 32'h0F0, 12};
    tbl[15] = '{1'b1, 16, 1'b1, 32'h0F1, 13};
    tbl[16] = '{1'b0, 17, 1'b1, 32'h0F1, 13};
    tbl[17] = '{1'b0, 18, 1'b1, 32'h0F1, 13};
    tbl[18] = '{1'b1, 19, 1'b1, 32'h0F2, 14};
    tbl[19] = '{1'b1, 20, 1'b1, 32'h0F3, 15};
    tbl[20] = '{1'b1, 21, 1'b1, 32'h150, 16};
    tbl[21] = '{1'b0, 22, 1'b1, 32'h150, 16};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(rd_valid), 128'(0));
    chk("rst_data", 128'(rd_data), 128'(0));
    chk("rst_count", 128'(word_count), 128'(0));
    chk("rst_err", 128'(stuck_err), 128'(0));
    rst = 1'b0;
    model_reset();

    // Warm-up, back-to-back streaming and backpressure.
    for (int i = 0; i < 22; i++) begin
      cycle_raw(tbl[i].rdy, R(tbl[i].seed));
      chk($sformatf("tbl%0d_valid", i), 128'(rd_valid), 128'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_data", i), 128'(rd_data), 128'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_count", i), 128'(word_count), 128'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_err", i), 128'(stuck_err), 128'(0));
    end

    // Stuck generator: constant input from the LOAD edge onward.
    do_reset();
    cycle_raw(1'b1, R(1));
    cycle_raw(1'b1, R(2));
    for (int k = 3; k <= 9; k++) begin
      cycle_raw(1'b1, 128'hDEAD);
      chk($sformatf("stuck_e%0d_valid", k), 128'(rd_valid), 128'(k < 6));
      chk($sformatf("stuck_e%0d_err", k), 128'(stuck_err), 128'(k >= 6));
      chk($sformatf("stuck_e%0d_count", k), 128'(word_count), 128'((k >= 6) ? 3 : k - 3));
      check_model($sformatf("stuck_m%0d", k));
    end
    #2 rst = 1'b1;
    #1;
    chk("async_err_clr", 128'(stuck_err), 128'(0));
    chk("async_err_valid", 128'(rd_valid), 128'(0));
    chk("async_err_count", 128'(word_count), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset mid-word with idx=2 and six words consumed.
    for (int k = 1; k <= 9; k++) cycle_raw(1'b1, R(k));
    chk("mid_count", 128'(word_count), 128'(6));
    chk("mid_data", 128'(rd_data), 128'(32'h072));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(rd_valid), 128'(0));
    chk("mid_rst_count", 128'(word_count), 128'(0));
    chk("mid_rst_err", 128'(stuck_err), 128'(0));
    chk("mid_rst_data", 128'(rd_data), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 3; k++) begin
      cycle_raw(1'b0, R(k));
      chk($sformatf("rewarm_e%0d_valid", k), 128'(rd_valid), 128'(k == 3));
    end
    chk("rewarm_data", 128'(rd_data), 128'(32'h030));

    // Counter wrap.
    force dut.r_word_count = 32'hFFFF_FFFF;
    #1 release dut.r_word_count;
    m_count = 32'hFFFF_FFFF;
    cycle_raw(1'b1, R(4));
    chk("wrap_count", 128'(word_count), 128'(0));
    chk("wrap_err", 128'(stuck_err), 128'(0));
    chk("wrap_valid", 128'(rd_valid), 128'(1));
    check_model("wrap_m");

    // Random run with frequent repeats so the stuck monitor sees short and long runs.
    last = R(99);
    for (int it = 0; it < 1200; it++) begin
      if ((m_err && $urandom_range(0, 2) == 0) || $urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) rin = last;
      else rin = {$urandom, $urandom, $urandom, $urandom};
      last = rin;
      cycle_raw($urandom_range(0, 3) != 0, rin);
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
